// File: rtl/opti_coef_loader.sv
// Coefficient loader for a four-section SOS cascade. It collects a framed, checksummed
// set of 20 Q2.22 words into a shadow bank and commits it atomically when swap_ok is high.
module opti_coef_loader (
  input  logic         clk,
  input  logic         rst,
  input  logic [23:0]  cfg_data,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic         cfg_abort,
  input  logic         swap_ok,
  output logic [479:0] coef_out,
  output logic         coef_update,
  output logic         load_err,
  output logic         busy
);

  localparam int unsigned N_WORDS  = 20;
  localparam logic [23:0] HEADER   = 24'hC50014;
  localparam logic [4:0]  LAST_IDX = 5'(N_WORDS - 1);
  // Pass-through set: each section has b0 = 1.0 and every other coefficient = 0.
  localparam logic [479:0] PASS_SET = {4{{96'h0, 24'h400000}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_COMMIT
  } state_e;

  state_e                     state_q, state_d;
  logic [4:0]                 cnt_q, cnt_d;
  logic [23:0]                acc_q, acc_d;
  logic [N_WORDS-1:0][23:0]   shadow_q, shadow_d;
  logic [479:0]               coef_q, coef_d;
  logic                       ready_q, ready_d;
  logic                       upd_q, upd_d;
  logic                       err_q, err_d;
  logic                       busy_q, busy_d;
  logic                       xfer;

  assign xfer = cfg_valid && ready_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    shadow_d = shadow_q;
    coef_d   = coef_q;
    upd_d    = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (xfer) begin
          if (cfg_data == HEADER) begin
            cnt_d   = '0;
            acc_d   = '0;
            state_d = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (cfg_abort) begin
          state_d = S_IDLE;
        end else if (xfer) begin
          shadow_d[cnt_q] = cfg_data;
          acc_d           = acc_q ^ cfg_data;
          cnt_d           = cnt_q + 5'd1;
          if (cnt_q == LAST_IDX) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (cfg_abort) begin
          state_d = S_IDLE;
        end else if (xfer) begin
          if (cfg_data == acc_q) begin
            state_d = S_COMMIT;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_COMMIT: begin
        if (cfg_abort) begin
          state_d = S_IDLE;
        end else if (swap_ok) begin
          // Shadow word i maps directly to coef_out[24i+23:24i], so the copy is a flat move.
          coef_d  = shadow_q;
          upd_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d != S_COMMIT);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      shadow_q <= '0;
      coef_q   <= PASS_SET;
      ready_q  <= 1'b0;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      shadow_q <= shadow_d;
      coef_q   <= coef_d;
      ready_q  <= ready_d;
      upd_q    <= upd_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign cfg_ready   = ready_q;
  assign coef_out    = coef_q;
  assign coef_update = upd_q;
  assign load_err    = err_q;
  assign busy        = busy_q;

endmodule

// File: doc/opti_coef_loader.md
Name: opti_coef_loader

Overview:
- Coefficient writer for a cascade of four opti_sos sections. The opti_sos sections read b0, b1, b2, a1 and a2 in Q2.22.
- Accepts a framed 24-bit configuration word stream over a valid/ready handshake and collects one full coefficient set into a shadow bank.
- Verifies a header and an XOR checksum, then commits the shadow bank to the active coefficient bus in one cycle, only when the filter signals that a swap is safe.
- Sits between the host/config interface and the SOS cascade.

Parameters:
- None. Fixed constants: 4 sections, 5 coefficients per section, 20 coefficient words, 24-bit Q2.22 words.
- Header word is 24'hC50014.

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  synchronous reset, active-high
- cfg_data  input  24  configuration word (header, coefficient or checksum)
- cfg_valid  input  1  cfg_data valid
- cfg_ready  output  1  loader can accept a word
- cfg_abort  input  1  discard the load in progress and return to IDLE
- swap_ok  input  1  the SOS cascade is between samples, so a coefficient swap is safe
- coef_out  output  480  active coefficients
  - Section k (k = 0..3) occupies bits [120k+119 : 120k].
  - Within a section, from the LSB upward: b0, b1, b2, a1, a2, 24 bits each.
- coef_update  output  1  one-cycle pulse: coef_out changed this cycle
- load_err  output  1  one-cycle pulse: bad header or checksum mismatch
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high; it is sampled on the rising edge of clk.
- Reset values:
  - State is IDLE. Word counter is 0. Checksum accumulator is 0. Shadow bank is 0.
  - coef_out is a pass-through set: every section has b0 = 24'h400000 (1.0 in Q2.22) and b1, b2, a1, a2 = 0.
  - cfg_ready = 0 during reset, and 1 in the cycle after reset releases.
  - coef_update, load_err and busy are 0.
- Transfer rule: a word transfers on a rising edge where cfg_valid and cfg_ready are both 1. Words with cfg_ready = 0 are ignored; the source must hold them.
- Registered outputs: all outputs are registered.
- States:
  - IDLE: cfg_ready = 1.
    - Header word == 24'hC50014: clear the counter and accumulator, go to LOAD.
    - Any other word: pulse load_err on the next cycle, stay in IDLE.
  - LOAD: cfg_ready = 1.
    - Each transferred word goes to shadow[cnt], the accumulator updates to acc ^ word, and cnt increments.
    - Order is section 0 b0, b1, b2, a1, a2, then section 1, and so on.
    - After the word with cnt = 19 transfers, go to CHECK.
  - CHECK: cfg_ready = 1.
    - Transferred word == acc: go to COMMIT.
    - Otherwise: pulse load_err, discard the shadow bank (coef_out unchanged), go to IDLE.
  - COMMIT: cfg_ready = 0.
    - On the first edge where swap_ok = 1: copy shadow to coef_out, pulse coef_update for exactly 1 cycle, go to IDLE.
    - Wait indefinitely while swap_ok = 0.
- Latency: checksum transferred on edge N → COMMIT during N..N+1. With swap_ok = 1 at edge N+1, coef_out takes the new values and coef_update = 1 during the cycle after edge N+1.
- Atomicity: coef_out never shows a partially written set. All 480 bits change on the same edge.
- cfg_abort:
  - In LOAD, CHECK or COMMIT: go to IDLE on the next edge. coef_out is unchanged, no load_err pulse, and any word presented on that edge is dropped.
  - Abort has priority over a simultaneous transfer and over swap_ok.
  - In IDLE: no effect.
- Reset mid-load or mid-COMMIT: takes priority over everything. coef_out returns to the pass-through set.
- Arithmetic: coefficients are stored bit-exact, with no saturation or scaling. The checksum is a 24-bit XOR over the 20 coefficient words only (the header is excluded).
- back-to-back frames: a new header is accepted in IDLE on the edge after commit or error.

Test Plan:
- Release reset → coef_out[23:0] = 24'h400000, coef_out[47:24] = 0, every section identical; cfg_ready = 1; busy = 0.
- Header C50014, words 1..20 (24'h000001..24'h000014), checksum 24'h000014 (XOR of 1..20), swap_ok = 1 → coef_update is a single pulse 2 cycles after the checksum edge; section0 b0 = 1, section3 a2 = 20; busy = 0 after.
- Same frame but checksum 24'h000000 → load_err pulses once, coef_out stays pass-through, coef_update never asserts.
- Valid frame with swap_ok held 0 for 10 cycles → cfg_ready = 0 and coef_out unchanged for those 10 cycles; commit on the first swap_ok = 1 edge.
- Header 24'hC50013 in IDLE → load_err pulse, state stays IDLE. Then a valid frame → loads normally.
- cfg_abort asserted after the 7th coefficient, then a full valid frame with values 24'h3FFFFF/24'hC00000 alternating → only the second frame reaches coef_out. A reset asserted during LOAD restores the pass-through set.
